// File: rtl/cpu_types_pkg.sv
// Shared CPU-side memory types: the bus word, the RAM handshake states seen by
// the memory controller, and the responder's internal FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    ERR  = 2'd3
  } ram_fsm_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } ram_op_t;

  localparam int LAT_MAX = 15;

endpackage

// File: rtl/ram_array.sv
// Single-port word RAM with synchronous read and synchronous write.
// Storage has no reset so contents survive nRST.
module ram_array
  import cpu_types_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          CLK,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  word_t         wdata,
  output word_t         rdata
);

  word_t r_mem [2**AW];

  always_ff @(posedge CLK) begin
    if (wen) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/memory_ram_responder.sv
// Latency-modelling RAM responder: holds each request BUSY for LAT cycles,
// then presents one ACCESS cycle; malformed requests park the FSM in ERROR.
module memory_ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT = 2,
  parameter int AW  = 14
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);

  localparam logic [3:0] CNT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  ram_fsm_t      r_state, w_state_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  word_t         r_addr, w_addr_nxt;
  ram_op_t       r_op, w_op_nxt;
  ram_op_t       w_op;
  logic          w_one, w_both, w_bad_addr, w_req, w_err, w_changed, w_wen;
  logic [AW-1:0] w_word;
  word_t         w_rdata;

  assign w_one      = ramREN ^ ramWEN;
  assign w_both     = ramREN & ramWEN;
  assign w_bad_addr = (ramaddr[1:0] != 2'b00) || ((ramaddr >> (AW + 2)) != '0);
  assign w_req      = w_one & ~w_bad_addr;
  assign w_err      = w_both | (w_one & w_bad_addr);
  assign w_op       = ramWEN ? OP_WRITE : OP_READ;
  assign w_changed  = (ramaddr != r_addr) || (w_op != r_op);
  assign w_word     = ramaddr[AW+1:2];

  // The array is addressed straight from the bus: on the edge entering ACC the
  // bus address equals the request, and a write only commits when it still does.
  assign w_wen = (r_state == ACC) && (r_op == OP_WRITE) && w_req && ramWEN &&
                 (ramaddr == r_addr);

  ram_array #(.AW(AW)) u_ram_array (
    .CLK   (CLK),
    .wen   (w_wen),
    .addr  (w_word),
    .wdata (ramstore),
    .rdata (w_rdata)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_op    <= OP_READ;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_op    <= w_op_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_op_nxt    = r_op;
    case (r_state)
      IDLE, ACC: begin
        if (w_err) begin
          w_state_nxt = ERR;
        end else if (w_req) begin
          w_addr_nxt  = ramaddr;
          w_op_nxt    = w_op;
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = (LAT == 0) ? ACC : WAIT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (w_err) begin
          w_state_nxt = ERR;
        end else if (!w_one) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (w_changed) begin
          w_addr_nxt = ramaddr;
          w_op_nxt   = w_op;
          w_cnt_nxt  = CNT_LOAD;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = ACC;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ERR: begin
        if (!ramREN && !ramWEN) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ramstate = FREE;
    case (r_state)
      IDLE:    ramstate = FREE;
      WAIT:    ramstate = BUSY;
      ACC:     ramstate = ACCESS;
      ERR:     ramstate = ERROR;
      default: ramstate = FREE;
    endcase
  end

  assign ramload = ((r_state == ACC) && (r_op == OP_READ)) ? w_rdata : '0;

endmodule

// File: tb/tb_memory_ram_responder.sv
// Directed bench for memory_ram_responder: a LAT=2 instance for the main
// scenarios and a LAT=0 instance for the zero-latency build.
module tb_memory_ram_responder;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic      ramREN0, ramWEN0;
  word_t     ramaddr0, ramstore0, ramload0;
  ramstate_t ramstate0;

  int n_checks;
  int n_fail;

  localparam word_t D80  = 32'hA0A0_0080;
  localparam word_t D84  = 32'hB1B1_0084;
  localparam word_t D100 = 32'hC2C2_0100;
  localparam word_t D104 = 32'hD3D3_0104;
  localparam word_t D10  = 32'h1111_1111;
  localparam word_t D00  = 32'h0000_5A00;

  memory_ram_responder #(.LAT(2), .AW(14)) dut (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  memory_ram_responder #(.LAT(0), .AW(14)) dut0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ramREN0), .ramWEN(ramWEN0),
    .ramaddr(ramaddr0), .ramstore(ramstore0), .ramload(ramload0), .ramstate(ramstate0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  // Issues one request from FREE, counts BUSY cycles until ACCESS, holds the
  // request through the ACC exit edge, then drops it and lets the FSM idle.
  task automatic run_access(input logic wr, input word_t addr, input word_t data,
                            output int busy, output word_t load, output logic ok);
    busy = 0; load = '0; ok = 1'b0;
    ramaddr = addr; ramstore = data; ramWEN = wr; ramREN = ~wr;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (ramstate == ACCESS) begin
        load = ramload; ok = 1'b1;
        break;
      end
      if (ramstate == BUSY) busy++;
    end
    if (ok) begin
      @(posedge CLK); #1;
    end
    ramREN = 1'b0; ramWEN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++;
    if (ramstate !== FREE) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", ramstate, FREE);
    end
    n_checks++;
    if (ramload !== 32'h0) begin
      n_fail++; $display("FAIL reset_load: got %h required %h", ramload, 32'h0);
    end
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic preload();
    int b; word_t l; logic ok;
    run_access(1'b1, 32'h80,  D80,  b, l, ok);
    run_access(1'b1, 32'h84,  D84,  b, l, ok);
    run_access(1'b1, 32'h100, D100, b, l, ok);
    run_access(1'b1, 32'h104, D104, b, l, ok);
    run_access(1'b1, 32'h10,  D10,  b, l, ok);
    run_access(1'b1, 32'h0,   D00,  b, l, ok);
  endtask

  task automatic test_write_read();
    int b; word_t l; logic ok;
    run_access(1'b1, 32'h40, 32'hDEADBEEF, b, l, ok);
    n_checks++;
    if (!ok || b !== 2) begin
      n_fail++; $display("FAIL wr_busy: got ok=%0d busy=%0d required ok=1 busy=2", ok, b);
    end
    run_access(1'b0, 32'h40, 32'h0, b, l, ok);
    n_checks++;
    if (!ok || b !== 2) begin
      n_fail++; $display("FAIL rd_busy: got ok=%0d busy=%0d required ok=1 busy=2", ok, b);
    end
    n_checks++;
    if (l !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_data: got %h required %h", l, 32'hDEADBEEF);
    end
  endtask

  task automatic test_back_to_back();
    int busy1, busy2; word_t l1, l2; logic ok1, ok2;
    busy1 = 0; busy2 = 0; l1 = '0; l2 = '0; ok1 = 1'b0; ok2 = 1'b0;
    ramREN = 1'b1; ramaddr = 32'h80;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (ramstate == ACCESS) begin
        l1 = ramload; ok1 = 1'b1;
        break;
      end
      if (ramstate == BUSY) begin
        busy1++;
        n_checks++;
        if (ramload !== 32'h0) begin
          n_fail++; $display("FAIL b2b_load_busy: got %h required %h", ramload, 32'h0);
        end
      end
    end
    ramaddr = 32'h84;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (ramstate == ACCESS) begin
        l2 = ramload; ok2 = 1'b1;
        break;
      end
      if (ramstate == BUSY) busy2++;
    end
    ramREN = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (!ok1 || busy1 !== 2) begin
      n_fail++; $display("FAIL b2b_busy1: got ok=%0d busy=%0d required ok=1 busy=2", ok1, busy1);
    end
    n_checks++;
    if (l1 !== D80) begin
      n_fail++; $display("FAIL b2b_data1: got %h required %h", l1, D80);
    end
    n_checks++;
    if (!ok2 || busy2 !== 2) begin
      n_fail++; $display("FAIL b2b_busy2: got ok=%0d busy=%0d required ok=1 busy=2", ok2, busy2);
    end
    n_checks++;
    if (l2 !== D84) begin
      n_fail++; $display("FAIL b2b_data2: got %h required %h", l2, D84);
    end
  endtask

  task automatic test_addr_change();
    ramREN = 1'b1; ramaddr = 32'h100;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== BUSY) begin
      n_fail++; $display("FAIL chg_first_busy: got %0d required %0d", ramstate, BUSY);
    end
    ramaddr = 32'h104;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      n_checks++;
      if (ramstate !== BUSY) begin
        n_fail++; $display("FAIL chg_busy%0d: got %0d required %0d", k, ramstate, BUSY);
      end
    end
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== ACCESS || ramload !== D104) begin
      n_fail++; $display("FAIL chg_access: got state=%0d load=%h required state=%0d load=%h",
                         ramstate, ramload, ACCESS, D104);
    end
    ramREN = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_errors();
    int b; word_t l; logic ok;
    ramREN = 1'b1; ramWEN = 1'b1; ramaddr = 32'h80; ramstore = 32'hBAD0BAD0;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== ERROR) begin
      n_fail++; $display("FAIL err_both: got %0d required %0d", ramstate, ERROR);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== ERROR) begin
      n_fail++; $display("FAIL err_hold: got %0d required %0d", ramstate, ERROR);
    end
    ramREN = 1'b0; ramWEN = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== FREE) begin
      n_fail++; $display("FAIL err_release: got %0d required %0d", ramstate, FREE);
    end
    ramWEN = 1'b1; ramaddr = 32'h3; ramstore = 32'hBAD1BAD1;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== ERROR) begin
      n_fail++; $display("FAIL err_misalign: got %0d required %0d", ramstate, ERROR);
    end
    ramWEN = 1'b0;
    @(posedge CLK); #1;
    ramWEN = 1'b1; ramaddr = 32'h0001_0000; ramstore = 32'hBAD2BAD2;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== ERROR) begin
      n_fail++; $display("FAIL err_range: got %0d required %0d", ramstate, ERROR);
    end
    ramWEN = 1'b0;
    @(posedge CLK); #1;
    ramREN = 1'b1; ramaddr = 32'h84;
    @(posedge CLK); #1;
    ramWEN = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== ERROR) begin
      n_fail++; $display("FAIL err_in_wait: got %0d required %0d", ramstate, ERROR);
    end
    ramREN = 1'b0; ramWEN = 1'b0;
    @(posedge CLK); #1;
    run_access(1'b0, 32'h80, 32'h0, b, l, ok);
    n_checks++;
    if (!ok || l !== D80) begin
      n_fail++; $display("FAIL err_nowrite80: got ok=%0d data=%h required ok=1 data=%h", ok, l, D80);
    end
    run_access(1'b0, 32'h0, 32'h0, b, l, ok);
    n_checks++;
    if (!ok || l !== D00) begin
      n_fail++; $display("FAIL err_nowrite0: got ok=%0d data=%h required ok=1 data=%h", ok, l, D00);
    end
  endtask

  task automatic test_reset_mid();
    int b; word_t l; logic ok;
    ramWEN = 1'b1; ramaddr = 32'h10; ramstore = 32'h2222_2222;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate !== BUSY) begin
      n_fail++; $display("FAIL rst_mid_busy: got %0d required %0d", ramstate, BUSY);
    end
    nRST = 1'b0;
    #1;
    n_checks++;
    if (ramstate !== FREE) begin
      n_fail++; $display("FAIL rst_mid_free: got %0d required %0d", ramstate, FREE);
    end
    ramWEN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    run_access(1'b0, 32'h10, 32'h0, b, l, ok);
    n_checks++;
    if (!ok || b !== 2 || l !== D10) begin
      n_fail++; $display("FAIL rst_mid_read: got ok=%0d busy=%0d data=%h required ok=1 busy=2 data=%h",
                         ok, b, l, D10);
    end
  endtask

  task automatic test_lat0();
    ramWEN0 = 1'b1; ramaddr0 = 32'h20; ramstore0 = 32'h5A5A_5A5A;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate0 !== ACCESS) begin
      n_fail++; $display("FAIL lat0_wr_access: got %0d required %0d", ramstate0, ACCESS);
    end
    @(posedge CLK); #1;
    ramWEN0 = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate0 !== FREE) begin
      n_fail++; $display("FAIL lat0_free: got %0d required %0d", ramstate0, FREE);
    end
    ramREN0 = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (ramstate0 !== ACCESS || ramload0 !== 32'h5A5A_5A5A) begin
      n_fail++; $display("FAIL lat0_rd_access: got state=%0d load=%h required state=%0d load=%h",
                         ramstate0, ramload0, ACCESS, 32'h5A5A_5A5A);
    end
    ramREN0 = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    nRST = 1'b0;
    ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
    ramREN0 = 1'b0; ramWEN0 = 1'b0; ramaddr0 = '0; ramstore0 = '0;
    test_reset();
    preload();
    test_write_read();
    test_back_to_back();
    test_addr_change();
    test_errors();
    test_reset_mid();
    test_lat0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_ram_responder.md
MEMORY_RAM_RESPONDER -- requirements
Module: memory_ram_responder

Interface
REQ-001 The block SHALL have parameter LAT, default 2, giving the number of BUSY wait cycles per access (legal 0..15).
REQ-002 The block SHALL have parameter AW, default 14, giving the word-address width; depth is 2^AW 32-bit words.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 ramREN  in  1  read request, held by the memory controller until ACCESS is observed.
REQ-006 ramWEN  in  1  write request, held by the memory controller until ACCESS is observed.
REQ-007 ramaddr  in  32  byte address; word index = ramaddr[AW+1:2].
REQ-008 ramstore  in  32  write data, sampled during ACCESS.
REQ-009 ramload  out  32  read data, valid while ramstate == ACCESS for a read.
REQ-010 ramstate  out  ramstate_t  FREE, BUSY, ACCESS or ERROR.

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT, ACC and ERR, driving ramstate FREE, BUSY, ACCESS and ERROR respectively; ramstate SHALL be a pure decode of the state register.
REQ-012 A request SHALL be defined as exactly one of ramREN or ramWEN high.
REQ-013 The request attributes, ramaddr and the op (read or write), SHALL be latched at every edge that enters WAIT or ACC from IDLE or ACC.
REQ-014 IDLE transitions:
  - valid request with LAT=0 -> ACC.
  - valid request with LAT>0 -> WAIT, with counter loaded to LAT-1.
  - no request -> stay in IDLE.
REQ-015 WAIT transitions:
  - counter decrements by 1 each cycle.
  - counter==0 with the request unchanged -> ACC.
REQ-016 In WAIT, a change of ramaddr or op versus the latched value SHALL restart the wait: counter reloads LAT-1, the new attributes are latched, and the state stays WAIT.
REQ-017 In WAIT, a dropped request (neither enable high) SHALL return the FSM to IDLE without any memory write.
REQ-018 For a read, ramload SHALL be registered from the array at the edge that enters ACC and held stable for the whole ACC cycle; ramload SHALL be 0 in all other states.
REQ-019 For a write, the array word SHALL be written with ramstore at the edge leaving ACC, and only if ramWEN is still high with the latched address.
REQ-020 ACC SHALL last exactly one cycle:
  - request still asserted at the exit edge -> a new access starts (WAIT, or ACC when LAT=0), re-latching attributes, so back-to-back block transfers each incur LAT.
  - otherwise -> IDLE.
REQ-021 ramREN and ramWEN both high, in any state, SHALL move the FSM to ERR at the next edge, with no array write.
REQ-022 A request with ramaddr[1:0] != 0, or with ramaddr[31:AW+2] != 0, SHALL move the FSM to ERR at the next edge, with no array write.
REQ-023 ERR SHALL persist while the offending request is held and return to IDLE at the first edge with both enables low.
REQ-024 Read-after-write to the same word SHALL return the newly written data, since the write commits before the following access begins.

Reset
REQ-025 While nRST is low, the block SHALL force state=IDLE, counter=0, latched addr/op=0 and ramload=0, so that ramstate=FREE.
REQ-026 Array contents SHALL NOT be affected by reset.
REQ-027 Reset asserted during WAIT or ACC SHALL abort the access with no array write; the first post-reset edge with a request SHALL start a fresh access.

Structure
REQ-028 ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t SHALL come from cpu_types_pkg; the block SHALL NOT redefine them.
REQ-029 The storage SHALL be a sub-module ram_array: single-port, synchronous read, synchronous write, with ports CLK, wen, addr[AW-1:0], wdata and rdata.
REQ-030 The FSM, counter and latching logic SHALL reside in memory_ram_responder.

Verification
REQ-031 Write then read, LAT=2:
  - stimulus: ramWEN, addr 0x40, data 0xDEADBEEF; hold until ACCESS, drop; then ramREN, addr 0x40.
  - required: BUSY,BUSY,ACCESS for each access; ramload=0xDEADBEEF during the read ACCESS.
REQ-032 Back-to-back block transfer:
  - stimulus: ramREN held; addr 0x80 until ACCESS, then 0x84.
  - required: two ACCESS pulses, each preceded by two BUSY cycles, returning the two prestored words in order.
REQ-033 Address change mid-WAIT:
  - stimulus: addr changes 0x100->0x104 after one BUSY cycle.
  - required: BUSY continues for two further cycles; ACCESS returns mem[0x104].
REQ-034 Error cases:
  - ramREN=ramWEN=1 -> ERROR next cycle, held until both low, then FREE.
  - addr 0x3 -> ERROR.
  - neither case writes the array.
REQ-035 Reset mid-operation:
  - stimulus: nRST pulsed low during WAIT of a write to 0x10, which holds 0x11111111.
  - required: ramstate=FREE immediately; a subsequent read of 0x10 returns 0x11111111.
REQ-036 LAT=0 build:
  - stimulus: ramREN.
  - required: ACCESS on the first cycle after the request edge, with no BUSY cycles.
